// File: rtl/exec_unit_mc_pkg.sv
// exec_pkg: op codes, FSM states and width helper shared by the execute stage
package exec_pkg;
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_ROL  = 4'd7;
   localparam logic [3:0] OP_BTR  = 4'd8;
   localparam logic [3:0] OP_MUL  = 4'd9;
   localparam logic [3:0] OP_DIVU = 4'd10;

   typedef enum logic {IDLE, ITER} state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction
endpackage

// File: rtl/exec_unit_mc_muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring divider on one shared adder
module muldiv_iter import exec_pkg::*; #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] q
);
   localparam int CW = clog2(WIDTH);
   logic             run, div, cout, ge;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] ra, rb, acc, rem_low, x, y, sum;
   // divide: remainder shifted left taking the next dividend bit; the bit leaving acc marks rem >= 2^WIDTH
   assign rem_low = {acc[WIDTH-2:0], ra[WIDTH-1]};
   assign x = div ? rem_low : acc;
   assign y = div ? ~rb : (rb[0] ? ra : '0);
   assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, div};
   assign ge = acc[WIDTH-1] | cout;
   assign done = run && cnt == CW'(WIDTH - 1);
   // q is the value after the current step, so the last step's answer is visible while done is high
   assign q = div ? {ra[WIDTH-2:0], ge} : sum;
   // load operands on start, then one multiply or divide step per cycle until the last bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run <= 1'b0;
         div <= 1'b0;
         cnt <= '0;
         ra  <= '0;
         rb  <= '0;
         acc <= '0;
      end else if (start) begin
         run <= 1'b1;
         div <= op_div;
         cnt <= '0;
         ra  <= a;
         rb  <= b;
         acc <= '0;
      end else if (run) begin
         run <= !done;
         cnt <= done ? '0 : cnt + 1'b1;
         acc <= div ? (ge ? sum : rem_low) : sum;
         ra  <= div ? {ra[WIDTH-2:0], ge} : ra << 1;
         rb  <= div ? rb : rb >> 1;
      end
   end
endmodule

// File: rtl/exec_unit_mc.sv
// exec_unit_mc: registered execute stage with valid/ready handshake and iterative MUL/DIVU
module exec_unit_mc import exec_pkg::*; #(
   parameter int WIDTH     = 16,
   parameter bit MULDIV_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] imm,
   input  logic             alu_src2,
   input  logic [WIDTH-1:0] pc_inc,
   input  logic             jump,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] branch_pc,
   output logic             zero,
   output logic             ofl,
   output logic             err,
   output logic             busy
);
   localparam int SW = clog2(WIDTH);
   state_t             state;
   logic [WIDTH-1:0]   opb, bpc, add_r, sub_r, btr, alu, md_q;
   logic [2*WIDTH-1:0] rol_d;
   logic               accept, div0, md_start, md_done, alu_ofl, alu_err;
   assign opb      = alu_src2 ? b : imm;
   assign bpc      = (jump ? a : pc_inc) + imm;
   assign add_r    = a + opb;
   assign sub_r    = a - opb;
   assign rol_d    = {a, a} << opb[SW-1:0];
   assign in_ready = state == IDLE && (!out_valid || out_ready);
   assign busy     = state == ITER;
   assign accept   = in_valid && in_ready;
   assign div0     = op == OP_DIVU && opb == '0;
   assign md_start = accept && MULDIV_EN && (op == OP_MUL || op == OP_DIVU) && !div0;
   assign alu_ofl  = op == OP_ADD ? (a[WIDTH-1] == opb[WIDTH-1] && add_r[WIDTH-1] != a[WIDTH-1]) :
                     op == OP_SUB ? (a[WIDTH-1] != opb[WIDTH-1] && sub_r[WIDTH-1] != a[WIDTH-1]) : 1'b0;

   muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk   (clk),
      .rst   (rst),
      .start (md_start),
      .op_div(op == OP_DIVU),
      .a     (a),
      .b     (opb),
      .done  (md_done),
      .q     (md_q)
   );

   // single-cycle result, including the divide-by-zero and disabled/reserved error cases
   always_comb begin
      btr     = '0;
      alu     = '0;
      alu_err = 1'b0;
      for (int i = 0; i < WIDTH; i++) btr[i] = a[WIDTH-1-i];
      case (op)
         OP_ADD:  alu = add_r;
         OP_SUB:  alu = sub_r;
         OP_AND:  alu = a & opb;
         OP_OR:   alu = a | opb;
         OP_XOR:  alu = a ^ opb;
         OP_SLL:  alu = a << opb[SW-1:0];
         OP_SRL:  alu = a >> opb[SW-1:0];
         OP_ROL:  alu = rol_d[2*WIDTH-1:WIDTH];
         OP_BTR:  alu = btr;
         OP_MUL, OP_DIVU: begin
            alu     = (MULDIV_EN && div0) ? {WIDTH{1'b1}} : '0;
            alu_err = !MULDIV_EN || div0;
         end
         default: alu_err = 1'b1;
      endcase
   end

   // FSM and output registers: load on accept or engine completion, hold under backpressure
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         branch_pc <= '0;
         zero      <= 1'b0;
         ofl       <= 1'b0;
         err       <= 1'b0;
      end else if (state == ITER) begin
         if (md_done) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            result    <= md_q;
            zero      <= md_q == '0;
         end
      end else if (accept) begin
         branch_pc <= bpc;
         ofl       <= alu_ofl;
         if (md_start) begin
            state     <= ITER;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            err       <= 1'b0;
         end else begin
            out_valid <= 1'b1;
            result    <= alu;
            zero      <= alu == '0;
            err       <= alu_err;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_exec_unit_mc.sv
// tb_exec_unit_mc: directed checks of ALU ops, iterative MUL/DIVU, handshake, branch and reset
module tb_exec_unit_mc;
   import exec_pkg::*;
   logic        clk = 1'b0, rst = 1'b0;
   logic        in_valid = 1'b0, in_ready, alu_src2 = 1'b0, jump = 1'b0, out_valid, out_ready = 1'b1;
   logic [3:0]  op = 4'd0;
   logic [15:0] a = '0, b = '0, imm = '0, pc_inc = '0, result, branch_pc;
   logic        zero, ofl, err, busy;
   int          errors = 0, checks = 0;

   typedef struct packed {logic [3:0] op; logic [15:0] a, b, r; logic ofl, err;} vec_t;
   vec_t alu_vec [12] = '{
      {OP_SUB,   16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0},
      {OP_SUB,   16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0},
      {OP_ADD,   16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0},
      {OP_AND,   16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0},
      {OP_OR,    16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0},
      {OP_XOR,   16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 1'b0},
      {OP_SLL,   16'h0001, 16'h0024, 16'h0010, 1'b0, 1'b0},
      {OP_SRL,   16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0},
      {OP_ROL,   16'h8001, 16'h0001, 16'h0003, 1'b0, 1'b0},
      {OP_BTR,   16'h0001, 16'h0000, 16'h8000, 1'b0, 1'b0},
      {4'd11,    16'h1234, 16'h0001, 16'h0000, 1'b0, 1'b1},
      {4'd15,    16'h1234, 16'h0001, 16'h0000, 1'b0, 1'b1}
   };

   exec_unit_mc #(.WIDTH(16), .MULDIV_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
      .imm(imm), .alu_src2(alu_src2), .pc_inc(pc_inc), .jump(jump), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .branch_pc(branch_pc), .zero(zero), .ofl(ofl),
      .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] o, input logic [15:0] av, bv, iv, input logic src2);
      in_valid = 1'b1;
      op = o;
      a = av;
      b = bv;
      imm = iv;
      alu_src2 = src2;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if ({out_valid, result, branch_pc, zero, ofl, err, busy} !== 37'd0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b r=%h bpc=%h z=%b o=%b e=%b busy=%b exp all 0",
                  out_valid, result, branch_pc, zero, ofl, err, busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_add_ofl();
      out_ready = 1'b1;
      drive(OP_ADD, 16'h7FFF, 16'h0000, 16'h0001, 1'b0);
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, result, ofl, zero, err} !== {1'b1, 16'h8000, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL add_ofl got v=%b r=%h o=%b z=%b e=%b exp v=1 r=8000 o=1 z=0 e=0",
                  out_valid, result, ofl, zero, err);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain out_valid got %b exp 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(alu_vec[i].op, alu_vec[i].a, alu_vec[i].b, 16'h0000, 1'b1);
         tick();
         checks++;
         if ({out_valid, in_ready, result, ofl, err, zero} !==
             {1'b1, 1'b1, alu_vec[i].r, alu_vec[i].ofl, alu_vec[i].err, alu_vec[i].r == 16'h0000}) begin
            errors++;
            $display("FAIL alu_vec%0d got v=%b rdy=%b r=%h o=%b e=%b z=%b exp r=%h o=%b e=%b", i, out_valid,
                     in_ready, result, ofl, err, zero, alu_vec[i].r, alu_vec[i].ofl, alu_vec[i].err);
         end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic run_md(input logic [3:0] o, input logic [15:0] av, bv, exp_r);
      out_ready = 1'b1;
      drive(o, av, bv, 16'h0000, 1'b1);
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 16; c++) begin
         checks++;
         if ({busy, in_ready, out_valid} !== 3'b100) begin
            errors++;
            $display("FAIL md_iter op=%0d cyc=%0d got busy=%b rdy=%b v=%b exp 1 0 0", o, c, busy, in_ready, out_valid);
         end
         tick();
      end
      checks++;
      if ({out_valid, busy, result, err, zero} !== {1'b1, 1'b0, exp_r, 1'b0, exp_r == 16'h0000}) begin
         errors++;
         $display("FAIL md_result op=%0d a=%h b=%h got v=%b busy=%b r=%h e=%b exp r=%h", o, av, bv,
                  out_valid, busy, result, err, exp_r);
      end
   endtask

   task automatic test_muldiv();
      run_md(OP_MUL, 16'h0012, 16'h0034, 16'h03A8);
      run_md(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001);
      run_md(OP_DIVU, 16'd100, 16'd7, 16'd14);
      run_md(OP_DIVU, 16'hFFFF, 16'h8001, 16'h0001);
      drive(OP_DIVU, 16'd5, 16'd0, 16'h0000, 1'b1);
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, busy, result, err, zero} !== {1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL div0 got v=%b busy=%b r=%h e=%b z=%b exp v=1 busy=0 r=ffff e=1 z=0",
                  out_valid, busy, result, err, zero);
      end
      tick();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(OP_ADD, 16'd3, 16'd4, 16'h0000, 1'b1);
      tick();
      drive(OP_XOR, 16'hF0F0, 16'h0FF0, 16'h0000, 1'b1);
      for (int c = 0; c < 3; c++) begin
         checks++;
         if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 16'd7}) begin
            errors++;
            $display("FAIL bp_hold cyc=%0d got v=%b rdy=%b r=%h exp v=1 rdy=0 r=0007", c, out_valid, in_ready, result);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, result} !== {1'b1, 16'hFF00}) begin
         errors++;
         $display("FAIL bp_reload got v=%b r=%h exp v=1 r=ff00", out_valid, result);
      end
      tick();
   endtask

   task automatic test_branch();
      out_ready = 1'b1;
      jump = 1'b0;
      pc_inc = 16'h0010;
      drive(OP_ADD, 16'h0000, 16'h0000, 16'hFFFC, 1'b0);
      tick();
      checks++;
      if (branch_pc !== 16'h000C) begin errors++; $display("FAIL branch_pc_inc got %h exp 000c", branch_pc); end
      jump = 1'b1;
      drive(OP_ADD, 16'h1000, 16'h0000, 16'h0004, 1'b0);
      tick();
      in_valid = 1'b0;
      jump = 1'b0;
      checks++;
      if ({branch_pc, result} !== {16'h1004, 16'h1004}) begin
         errors++;
         $display("FAIL branch_jump got bpc=%h r=%h exp bpc=1004 r=1004", branch_pc, result);
      end
      tick();
   endtask

   task automatic test_reset_mid_mul();
      out_ready = 1'b1;
      drive(OP_MUL, 16'h0012, 16'h0034, 16'h0000, 1'b1);
      tick();
      in_valid = 1'b0;
      repeat (8) tick();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL mid_mul_busy got %b exp 1", busy); end
      rst = 1'b0;
      #1;
      checks++;
      if ({out_valid, result, branch_pc, zero, ofl, err, busy} !== 37'd0) begin
         errors++;
         $display("FAIL mid_reset got v=%b r=%h bpc=%h z=%b o=%b e=%b busy=%b exp all 0",
                  out_valid, result, branch_pc, zero, ofl, err, busy);
      end
      tick();
      rst = 1'b1;
      drive(OP_ADD, 16'd1, 16'd1, 16'h0000, 1'b1);
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, busy, result} !== {1'b1, 1'b0, 16'd2}) begin
         errors++;
         $display("FAIL post_reset_add got v=%b busy=%b r=%h exp v=1 busy=0 r=0002", out_valid, busy, result);
      end
      repeat (16) tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL aborted_mul_leak got v=%b busy=%b exp 0 0", out_valid, busy);
      end
   endtask

   initial begin
      test_reset();
      test_add_ofl();
      test_back_to_back();
      test_muldiv();
      test_backpressure();
      test_branch();
      test_reset_mid_mul();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
